// File: rtl/sdelta_dec_pkg.sv
// Shared definitions for the streaming signed delta decoder: state encoding
// and the signed-add overflow detector used by the adder/subtractor family.
package sdelta_dec_pkg;

    localparam logic [1:0] SDD_IDLE  = 2'd0;
    localparam logic [1:0] SDD_RUN   = 2'd1;
    localparam logic [1:0] SDD_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = SDD_IDLE,
        StRun   = SDD_RUN,
        StDrain = SDD_DRAIN
    } sdd_state_e;

    // Width-agnostic: operands and result are passed as their sign bits only.
    function automatic logic sdd_add_ovf(input logic a_sign,
                                         input logic b_sign,
                                         input logic sum_sign);
        return (a_sign == b_sign) && (sum_sign != a_sign);
    endfunction

endpackage

// File: rtl/sdelta_outreg.sv
// Valid/ready output register stage: holds one reconstructed sample and its
// last flag, and reports whether a new sample may be loaded this cycle.
module sdelta_outreg #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 last_i,
    input  logic                 out_ready_i,
    output logic                 ready_o,
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] value_o,
    output logic                 out_last_o
);

    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [DataWidth-1:0] data_q, data_d;

    // A load may replace a sample being consumed in the same cycle (no bubble).
    assign ready_o = !valid_q || out_ready_i;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            last_d  = last_i;
            data_d  = data_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign value_o     = data_q;

endmodule

// File: rtl/sdelta_dec.sv
// Streaming signed delta decoder: integrates accepted differences onto a
// loaded base value, with a sticky signed-overflow flag per stream.
module sdelta_dec
    import sdelta_dec_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DATAWIDTH-1:0] base_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATAWIDTH-1:0] diff_i,
    input  logic                 in_last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] value_o,
    output logic                 out_last_o,
    output logic                 ovf_o,
    output logic                 busy_o
);

    sdd_state_e           state_q, state_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [DATAWIDTH-1:0] sum;
    logic                 outreg_ready;
    logic                 accept;

    // Wrapping add is the exact inverse of the transmitter's wrapping subtract.
    assign sum        = acc_q + diff_i;
    assign in_ready_o = (state_q == StRun) && outreg_ready;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d   = base_i;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    acc_d = sum;
                    ovf_d = ovf_q | sdd_add_ovf(acc_q[DATAWIDTH-1], diff_i[DATAWIDTH-1],
                                                sum[DATAWIDTH-1]);
                    if (in_last_i) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!out_valid_o || out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    sdelta_outreg #(
        .DataWidth (DATAWIDTH)
    ) u_outreg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .data_i      (sum),
        .last_i      (in_last_i),
        .out_ready_i (out_ready_i),
        .ready_o     (outreg_ready),
        .out_valid_o (out_valid_o),
        .value_o     (value_o),
        .out_last_o  (out_last_o)
    );

    assign ovf_o  = ovf_q;
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_sdelta_dec.sv
// Directed and loopback bench for sdelta_dec at DATAWIDTH=8.
module tb_sdelta_dec;

    localparam int unsigned DW = 8;
    localparam int NS = 48;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [DW-1:0] base_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] diff_i;
    logic          in_last_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] value_o;
    logic          out_last_o;
    logic          ovf_o;
    logic          busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    sdelta_dec #(
        .DATAWIDTH (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_i      (base_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .diff_i      (diff_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .value_o     (value_o),
        .out_last_o  (out_last_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic begin_stream(input logic [DW-1:0] b);
        start_i = 1'b1;
        base_i  = b;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; base_i = '0; in_valid_i = 1'b0;
        diff_i = '0; in_last_i = 1'b0; out_ready_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        n_vec++;
        if (out_valid_o !== 1'b0 || value_o !== 8'h00 || out_last_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: valid=%b value=%h last=%b, want 0/00/0",
                     out_valid_o, value_o, out_last_o);
        end
        n_vec++;
        if (ovf_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctl: ovf=%b busy=%b in_ready=%b, want 0/0/0",
                     ovf_o, busy_o, in_ready_o);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] dv [3];
        logic [DW-1:0] ev [3];
        dv[0] = 8'd5;  dv[1] = 8'hFD; dv[2] = 8'd20;
        ev[0] = 8'd15; ev[1] = 8'd12; ev[2] = 8'd32;
        begin_stream(8'd10);
        n_vec++;
        if (in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL basic_run: in_ready=%b busy=%b, want 1/1", in_ready_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            diff_i     = dv[i];
            in_last_i  = (i == 2);
            tick();
            n_vec++;
            if (out_valid_o !== 1'b1 || value_o !== ev[i] || out_last_o !== (i == 2)) begin
                n_err++;
                $display("FAIL basic_val%0d: valid=%b value=%0d last=%b, want 1/%0d/%b",
                         i, out_valid_o, value_o, out_last_o, ev[i], (i == 2));
            end
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        #1;
        n_vec++;
        if (ovf_o !== 1'b0 || busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_drain: ovf=%b busy=%b in_ready=%b, want 0/1/0",
                     ovf_o, busy_o, in_ready_o);
        end
        tick();
        n_vec++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle: busy=%b valid=%b, want 0/0", busy_o, out_valid_o);
        end
    endtask

    task automatic test_overflow();
        begin_stream(8'd120);
        in_valid_i = 1'b1; diff_i = 8'd10;
        tick();
        n_vec++;
        if (value_o !== 8'h82 || ovf_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_wrap: value=%h ovf=%b, want 82/1", value_o, ovf_o);
        end
        diff_i = 8'hF6; in_last_i = 1'b1;
        tick();
        n_vec++;
        if (value_o !== 8'd120 || ovf_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: value=%0d ovf=%b, want 120/1", value_o, ovf_o);
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        tick();
        n_vec++;
        if (ovf_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_idle: ovf=%b busy=%b, want 1/0", ovf_o, busy_o);
        end
        begin_stream(8'd0);
        n_vec++;
        if (ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b, want 0", ovf_o);
        end
    endtask

    // Entered in RUN with accumulator 0.
    task automatic test_backpressure();
        in_valid_i = 1'b1; diff_i = 8'd1; out_ready_i = 1'b1;
        tick();
        n_vec++;
        if (value_o !== 8'd1 || out_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first: value=%0d valid=%b, want 1/1", value_o, out_valid_o);
        end
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (in_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready%0d: in_ready=%b, want 0", i, in_ready_o);
            end
            tick();
            n_vec++;
            if (value_o !== 8'd1 || out_valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: value=%0d valid=%b, want 1/1",
                         i, value_o, out_valid_o);
            end
        end
        out_ready_i = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            in_last_i = (k == 5);
            tick();
            n_vec++;
            if (value_o !== k[DW-1:0] || out_valid_o !== 1'b1 || out_last_o !== (k == 5)) begin
                n_err++;
                $display("FAIL bp_flow%0d: value=%0d valid=%b last=%b, want %0d/1/%b",
                         k, value_o, out_valid_o, out_last_o, k, (k == 5));
            end
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        tick();
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: busy=%b, want 0", busy_o);
        end
    endtask

    task automatic test_mid_reset();
        begin_stream(8'd120);
        out_ready_i = 1'b0; in_valid_i = 1'b1; diff_i = 8'd10;
        tick();
        in_valid_i = 1'b0;
        n_vec++;
        if (out_valid_o !== 1'b1 || ovf_o !== 1'b1) begin
            n_err++;
            $display("FAIL mrst_pre: valid=%b ovf=%b, want 1/1", out_valid_o, ovf_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        n_vec++;
        if (out_valid_o !== 1'b0 || value_o !== 8'h00 || ovf_o !== 1'b0 ||
            in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_post: valid=%b value=%h ovf=%b in_ready=%b busy=%b, want 0/00/0/0/0",
                     out_valid_o, value_o, ovf_o, in_ready_o, busy_o);
        end
        out_ready_i = 1'b1;
        begin_stream(8'd5);
        in_valid_i = 1'b1; diff_i = 8'd3; in_last_i = 1'b1;
        tick();
        n_vec++;
        if (value_o !== 8'd8 || out_valid_o !== 1'b1 || ovf_o !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_restart: value=%0d valid=%b ovf=%b, want 8/1/0",
                     value_o, out_valid_o, ovf_o);
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        tick();
    endtask

    task automatic test_ignored();
        begin_stream(8'd0);
        in_valid_i = 1'b1; diff_i = 8'd2;
        tick();
        in_valid_i = 1'b0; start_i = 1'b1; base_i = 8'd100;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; diff_i = 8'd1;
        tick();
        n_vec++;
        if (value_o !== 8'd3 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL ign_run_start: value=%0d busy=%b, want 3/1", value_o, busy_o);
        end
        in_last_i = 1'b1;
        tick();
        in_valid_i = 1'b0; in_last_i = 1'b0;
        out_ready_i = 1'b0; start_i = 1'b1; base_i = 8'd50;
        tick();
        n_vec++;
        if (value_o !== 8'd4 || busy_o !== 1'b1 || out_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL ign_drain_start: value=%0d busy=%b valid=%b, want 4/1/1",
                     value_o, busy_o, out_valid_o);
        end
        out_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL ign_drain_idle: busy=%b, want 0", busy_o);
        end
        start_i = 1'b1; base_i = 8'd20; in_valid_i = 1'b1; diff_i = 8'd99;
        #1;
        n_vec++;
        if (in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL ign_idle_ready: in_ready=%b, want 0", in_ready_o);
        end
        tick();
        start_i = 1'b0;
        n_vec++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL ign_idle_diff: valid=%b busy=%b, want 0/1", out_valid_o, busy_o);
        end
        diff_i = 8'd1; in_last_i = 1'b1;
        tick();
        n_vec++;
        if (value_o !== 8'd21 || out_last_o !== 1'b1) begin
            n_err++;
            $display("FAIL ign_idle_base: value=%0d last=%b, want 21/1", value_o, out_last_o);
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        logic [DW-1:0] s [NS];
        int idx;
        int oidx;
        int cycles;
        for (int i = 0; i < NS; i++) s[i] = DW'($urandom);
        begin_stream(s[0]);
        idx = 0; oidx = 0; cycles = 0;
        while (oidx < NS - 1 && cycles < 2000) begin
            in_valid_i  = (idx < NS - 1) && ($urandom_range(0, 3) != 0);
            diff_i      = (idx < NS - 1) ? s[idx+1] - s[idx] : '0;
            in_last_i   = (idx == NS - 2);
            out_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid_o && out_ready_i) begin
                n_vec++;
                if (value_o !== s[oidx+1] || out_last_o !== (oidx == NS - 2)) begin
                    n_err++;
                    $display("FAIL loop_s%0d: value=%h last=%b, want %h/%b",
                             oidx + 1, value_o, out_last_o, s[oidx+1], (oidx == NS - 2));
                end
                oidx++;
            end
            if (in_valid_i && in_ready_o) idx++;
            tick();
            cycles++;
        end
        n_vec++;
        if (oidx != NS - 1) begin
            n_err++;
            $display("FAIL loop_count: got %0d samples, want %0d (timeout)", oidx, NS - 1);
        end
        in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b1;
        tick();
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL loop_idle: busy=%b, want 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        test_ignored();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdelta_dec.md
# sdelta_dec

Streaming signed delta decoder: the receiving end of a difference-encoded datapath whose transmitter emits `diff = a - b` of consecutive signed samples. Starting from a loaded base value, it integrates each accepted difference to reconstruct the original sample stream. It sits in the generated datapath library beside the arithmetic components. It uses valid/ready handshakes on both sides so it can be chained with registered datapath stages.

## Interface
- DATAWIDTH, 64, width of base, differences and reconstructed values (signed, two's complement)

- Clk  in  1  single clock; all state changes on rising edge
- Rst  in  1  synchronous, active-high reset
- Start  in  1  load `Base` into accumulator, begin a stream (honoured in IDLE only)
- Base  in  DATAWIDTH signed  initial sample value (the sample preceding the first difference)
- InValid  in  1  `Diff`/`InLast` valid
- InReady  out  1  decoder can accept a difference this cycle
- Diff  in  DATAWIDTH signed  next difference
- InLast  in  1  this difference is the last of the stream
- OutValid  out  1  `Value` holds a reconstructed sample
- OutReady  in  1  downstream accepts `Value` this cycle
- Value  out  DATAWIDTH signed  reconstructed sample
- OutLast  out  1  `Value` is the last sample of the stream
- Ovf  out  1  sticky: signed overflow (wrap) occurred in this stream
- Busy  out  1  high in RUN and DRAIN

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - InReady=0.
  - Start=1: acc<=Base, Ovf<=0, go RUN.
  - InValid is ignored.
- RUN:
  - InReady = !OutValid || OutReady.
  - Accept when InValid && InReady: acc<=acc+Diff, Value<=acc+Diff, OutValid<=1, OutLast<=InLast.
  - Accept with InLast=1: go DRAIN.
  - Start is ignored.
- DRAIN:
  - InReady=0.
  - When OutValid && OutReady: OutValid<=0, OutLast<=0, go IDLE.
  - Start is ignored until IDLE is reached.
- Output register:
  - When OutValid && OutReady with no new accept, OutValid<=0.
  - When both happen in the same cycle, the new sample replaces the old one, OutValid stays 1, and there is no bubble.
- Arithmetic:
  - Sum is taken modulo 2^DATAWIDTH (wrap-around). This is the exact inverse of the wrapping subtractor, so reconstruction is bit-exact even when Ovf=1.
  - Ovf<=1 when the operands have equal sign bits and the result sign differs.
  - Ovf stays set until the next accepted Start or Rst.
- Reset (Rst=1, any state, including mid-stream):
  - State=IDLE, acc=0, Value=0, OutValid=0, OutLast=0, Ovf=0, Busy=0, InReady=0.
  - Any sample held in the output register is discarded.
- Start and InValid together in IDLE: only Start acts; that Diff is not accepted (InReady=0).

## Timing
- Start accepted at edge N: RUN from cycle N+1; InReady=1 in cycle N+1.
- Diff accepted at edge N: Value/OutValid valid from cycle N+1. Latency 1 cycle.
- Throughput: 1 difference per cycle while OutReady=1.
- Holding under backpressure: while OutValid && !OutReady, Value, OutLast and OutValid hold, and InReady=0.
- InReady depends combinationally on OutReady. There is no other input-to-output combinational path.
- Last-sample turnaround: InLast accepted at edge N → DRAIN from N+1. With OutReady=1 in N+1, the block is in IDLE at N+2 and a new Start can be accepted at edge N+2.
- Busy is registered-state-derived and glitch-free.

## Structure
- Shared package/include holds:
  - state encoding constants SDD_IDLE, SDD_RUN, SDD_DRAIN (2-bit)
  - overflow-detect function sdd_add_ovf(a, b, sum), reused by the signed adder/subtractor components.
- One sub-module: `sdelta_outreg`, the valid/ready output register stage holding Value/OutLast/OutValid and producing the ready term.
- The accumulator, FSM and Ovf logic stay in the top.

## Test plan
- DATAWIDTH=8, Start with Base=10, Diffs +5, -3, +20 with InLast on the third, OutReady=1 → Value 15, 12, 32 on consecutive cycles; OutLast on 32; Ovf=0; IDLE two cycles after the last accept.
- DATAWIDTH=8, Base=120, Diff=+10 → Value=-126 (0x82) and Ovf=1. Next Diff=-10 → Value=120 with Ovf still 1. A new Start clears Ovf.
- Backpressure:
  - Setup: OutReady=0 for 3 cycles after the first output, with InValid held and Diff=+1.
  - Required: InReady=0 and Value stable for those 3 cycles.
  - After release: one output per cycle with no lost or duplicated samples.
- Rst asserted in RUN with OutValid=1 → next cycle OutValid=0, Value=0, Ovf=0, InReady=0, Busy=0. A following Start works normally.
- Ignored inputs:
  - Start pulsed in RUN and in DRAIN → accumulator unchanged.
  - Start+InValid together in IDLE → only Base is loaded and the Diff is not consumed.
- Random loopback: random signed samples are encoded with a wrapping subtract model and fed with random InValid/OutReady → decoded stream equals the original samples bit-exactly.
